// File: rtl/sha_round_ctrl_if.sv
// Host-side bundle of sha_round_ctrl: command/status register, message-word
// load strobe and digest readout handshake.
interface sha_round_ctrl_if;
  logic [2:0] cmd_i;
  logic       cmd_w_i;
  logic [3:0] cmd_o;
  logic       text_w_i;
  logic [3:0] wr_idx_o;
  logic       blk_full_o;
  logic       rd_vld_o;
  logic [2:0] rd_idx_o;
  logic       rd_ack_i;
  logic       err_o;

  modport master (
    output cmd_i, cmd_w_i, text_w_i, rd_ack_i,
    input  cmd_o, wr_idx_o, blk_full_o, rd_vld_o, rd_idx_o, err_o
  );

  modport slave (
    input  cmd_i, cmd_w_i, text_w_i, rd_ack_i,
    output cmd_o, wr_idx_o, blk_full_o, rd_vld_o, rd_idx_o, err_o
  );
endinterface

// File: rtl/sha_round_ctrl.sv
// Command and sequencing controller for iterative SHA-1/224/256 cores.
// Keeps the host command/status register, counts loaded message words,
// steps the compression rounds and walks the digest readout. The datapath
// itself lives elsewhere; this block only tells it what to do each cycle.
module sha_round_ctrl #(
  parameter int ROUNDS       = 64,
  parameter int BLOCK_WORDS  = 16,
  parameter int DIGEST_WORDS = 8,
  parameter int RW           = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sha_round_ctrl_if.slave host,
  output logic          init_o,
  output logic          round_en_o,
  output logic [RW-1:0] round_o,
  output logic          final_o,
  output logic          done_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_e;

  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
  localparam logic [4:0]    FULL_CNT   = 5'(BLOCK_WORDS);
  localparam logic [2:0]    LAST_RD    = 3'(DIGEST_WORDS - 1);

  state_e        state_q, state_d;
  logic [2:0]    cmd_q, cmd_d;
  logic          busy_dly_q, busy_dly_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [RW-1:0] round_q, round_d;
  logic          init_q, init_d;
  logic          round_en_q, round_en_d;
  logic          final_q, final_d;
  logic          done_q, done_d;
  logic          rd_vld_q, rd_vld_d;
  logic [2:0]    rd_idx_q, rd_idx_d;
  logic          err_q, err_d;

  logic idle;
  logic full;
  logic rd_load;
  logic start;

  // Readout takes priority over a pending start, and a start never begins
  // while a digest is still being read out.
  assign idle    = (state_q == ST_IDLE);
  assign full    = (cnt_q == FULL_CNT);
  assign rd_load = idle && cmd_q[0];
  assign start   = idle && cmd_q[1] && full && !cmd_q[0] && !rd_vld_q;

  // Next-state logic: block sequencing, readout, word count, command and error.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    busy_dly_d = !idle;
    cnt_d      = cnt_q;
    round_d    = round_q;
    init_d     = 1'b0;
    round_en_d = 1'b0;
    final_d    = 1'b0;
    done_d     = 1'b0;
    rd_vld_d   = rd_vld_q;
    rd_idx_d   = rd_idx_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ROUND;
          round_d    = '0;
          round_en_d = 1'b1;
          init_d     = !cmd_q[2];
          cnt_d      = '0;
          cmd_d[1]   = 1'b0;
        end
      end
      ST_ROUND: begin
        if (round_q == LAST_ROUND) begin
          state_d = ST_FINAL;
          final_d = 1'b1;
        end else begin
          round_d    = round_q + 1'b1;
          round_en_d = 1'b1;
        end
      end
      ST_FINAL: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rd_load) begin
      rd_vld_d = 1'b1;
      rd_idx_d = '0;
      cmd_d[0] = 1'b0;
    end else if (host.rd_ack_i && rd_vld_q) begin
      if (rd_idx_q == LAST_RD) begin
        rd_vld_d = 1'b0;
      end else begin
        rd_idx_d = rd_idx_q + 3'd1;
      end
    end

    if (host.text_w_i && idle && !full) begin
      cnt_d = cnt_q + 5'd1;
    end

    if (host.cmd_w_i && idle) begin
      cmd_d = host.cmd_i;
      err_d = 1'b0;
    end

    if ((host.cmd_w_i && !idle) ||
        (host.text_w_i && !(idle && !full)) ||
        (host.rd_ack_i && !rd_vld_q)) begin
      err_d = 1'b1;
    end
  end

  // Single state register for the FSM and all of its registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      busy_dly_q <= 1'b0;
      cnt_q      <= '0;
      round_q    <= '0;
      init_q     <= 1'b0;
      round_en_q <= 1'b0;
      final_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      busy_dly_q <= busy_dly_d;
      cnt_q      <= cnt_d;
      round_q    <= round_d;
      init_q     <= init_d;
      round_en_q <= round_en_d;
      final_q    <= final_d;
      done_q     <= done_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
      err_q      <= err_d;
    end
  end

  assign host.cmd_o      = {busy_dly_q, cmd_q};
  assign host.wr_idx_o   = cnt_q[3:0];
  assign host.blk_full_o = full;
  assign host.rd_vld_o   = rd_vld_q;
  assign host.rd_idx_o   = rd_idx_q;
  assign host.err_o      = err_q;

  assign init_o     = init_q;
  assign round_en_o = round_en_q;
  assign round_o    = round_q;
  assign final_o    = final_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Self-checking bench for sha_round_ctrl: two instances (64 rounds / 8 digest
// words and 80 rounds / 5 digest words) exercised one at a time through a
// shared stimulus path and compared against a timestamp-based reference model.
module tb_sha_round_ctrl;
  localparam int RW = 7;

  logic clk = 1'b0;
  logic rst_n;

  // Free-running clock.
  always #5 clk = ~clk;

  bit       sel;
  logic [2:0] drv_cmd;
  logic       drv_cmd_w;
  logic       drv_text_w;
  logic       drv_ack;

  sha_round_ctrl_if host_a ();
  sha_round_ctrl_if host_b ();

  logic          init_a, round_en_a, final_a, done_a;
  logic [RW-1:0] round_a;
  logic          init_b, round_en_b, final_b, done_b;
  logic [RW-1:0] round_b;

  sha_round_ctrl #(.ROUNDS(64), .BLOCK_WORDS(16), .DIGEST_WORDS(8), .RW(RW)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .host(host_a),
    .init_o(init_a), .round_en_o(round_en_a), .round_o(round_a),
    .final_o(final_a), .done_o(done_a)
  );

  sha_round_ctrl #(.ROUNDS(80), .BLOCK_WORDS(16), .DIGEST_WORDS(5), .RW(RW)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .host(host_b),
    .init_o(init_b), .round_en_o(round_en_b), .round_o(round_b),
    .final_o(final_b), .done_o(done_b)
  );

  assign host_a.cmd_i    = sel ? 3'd0 : drv_cmd;
  assign host_a.cmd_w_i  = sel ? 1'b0 : drv_cmd_w;
  assign host_a.text_w_i = sel ? 1'b0 : drv_text_w;
  assign host_a.rd_ack_i = sel ? 1'b0 : drv_ack;
  assign host_b.cmd_i    = sel ? drv_cmd    : 3'd0;
  assign host_b.cmd_w_i  = sel ? drv_cmd_w  : 1'b0;
  assign host_b.text_w_i = sel ? drv_text_w : 1'b0;
  assign host_b.rd_ack_i = sel ? drv_ack    : 1'b0;

  logic [3:0]    obs_cmd, obs_wr_idx;
  logic          obs_full, obs_rd_vld, obs_err;
  logic [2:0]    obs_rd_idx;
  logic          obs_init, obs_round_en, obs_final, obs_done;
  logic [RW-1:0] obs_round;

  assign obs_cmd      = sel ? host_b.cmd_o      : host_a.cmd_o;
  assign obs_wr_idx   = sel ? host_b.wr_idx_o   : host_a.wr_idx_o;
  assign obs_full     = sel ? host_b.blk_full_o : host_a.blk_full_o;
  assign obs_rd_vld   = sel ? host_b.rd_vld_o   : host_a.rd_vld_o;
  assign obs_rd_idx   = sel ? host_b.rd_idx_o   : host_a.rd_idx_o;
  assign obs_err      = sel ? host_b.err_o      : host_a.err_o;
  assign obs_init     = sel ? init_b     : init_a;
  assign obs_round_en = sel ? round_en_b : round_en_a;
  assign obs_round    = sel ? round_b    : round_a;
  assign obs_final    = sel ? final_b    : final_a;
  assign obs_done     = sel ? done_b     : done_a;

  int total = 0;
  int bad   = 0;

  // Reference model: host-visible registers plus the timestamp of the last start.
  int       m_rounds;
  int       m_digest;
  int       edge_n;
  bit       has_block;
  int       t_start;
  bit       m_init_bit;
  bit [2:0] m_cmd;
  int       m_count;
  bit       m_err;
  bit       m_rd_act;
  int       m_rd_idx;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d, sel %0d)",
               tag, observed, expected, edge_n, sel);
    end
  endtask

  function automatic int model_k();
    return edge_n - t_start;
  endfunction

  function automatic bit model_busy();
    return has_block && (model_k() <= m_rounds + 1);
  endfunction

  task automatic model_reset();
    has_block = 1'b0;
    t_start   = 0;
    m_cmd     = 3'd0;
    m_count   = 0;
    m_err     = 1'b0;
    m_rd_act  = 1'b0;
    m_rd_idx  = 0;
  endtask

  task automatic model_step();
    bit       idle, do_read, do_start, text_ok, rd_pre;
    bit [2:0] c_next;
    bit       e_next;
    idle     = !model_busy();
    rd_pre   = m_rd_act;
    do_read  = idle && m_cmd[0];
    do_start = idle && m_cmd[1] && (m_count == 16) && !m_cmd[0] && !rd_pre;
    text_ok  = idle && (m_count < 16);
    c_next   = m_cmd;
    e_next   = m_err;

    if (do_read) begin
      m_rd_act  = 1'b1;
      m_rd_idx  = 0;
      c_next[0] = 1'b0;
    end else if (drv_ack && rd_pre) begin
      if (m_rd_idx == m_digest - 1) m_rd_act = 1'b0;
      else m_rd_idx++;
    end

    if (do_start) begin
      m_count   = 0;
      c_next[1] = 1'b0;
    end else if (drv_text_w && text_ok) begin
      m_count++;
    end

    if (drv_cmd_w && idle) begin
      c_next = drv_cmd;
      e_next = 1'b0;
    end
    if ((drv_cmd_w && !idle) || (drv_text_w && !text_ok) || (drv_ack && !rd_pre))
      e_next = 1'b1;

    edge_n++;
    if (do_start) begin
      has_block  = 1'b1;
      t_start    = edge_n;
      m_init_bit = !m_cmd[2];
    end
    m_cmd = c_next;
    m_err = e_next;
  endtask

  task automatic compare_all();
    int k;
    bit exp_en, cmd3;
    k      = model_k();
    exp_en = has_block && (k >= 0) && (k < m_rounds);
    cmd3   = has_block && (k >= 1) && (k <= m_rounds + 2);
    checkOutput("round_en", obs_round_en, exp_en);
    if (exp_en) checkOutput("round_idx", obs_round, k);
    checkOutput("init", obs_init, exp_en && (k == 0) && m_init_bit);
    checkOutput("final", obs_final, has_block && (k == m_rounds));
    checkOutput("done", obs_done, has_block && (k == m_rounds + 1));
    checkOutput("cmd_status", obs_cmd, {cmd3, m_cmd});
    checkOutput("wr_idx", obs_wr_idx, m_count % 16);
    checkOutput("blk_full", obs_full, m_count == 16);
    checkOutput("rd_vld", obs_rd_vld, m_rd_act);
    if (m_rd_act) checkOutput("rd_idx", obs_rd_idx, m_rd_idx);
    checkOutput("err", obs_err, m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic applyStimulus(input bit cw, input bit [2:0] c, input bit tw, input bit ack);
    drv_cmd_w  = cw;
    drv_cmd    = c;
    drv_text_w = tw;
    drv_ack    = ack;
    tick();
    drv_cmd_w  = 1'b0;
    drv_cmd    = 3'd0;
    drv_text_w = 1'b0;
    drv_ack    = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    drv_cmd_w  = 1'b0;
    drv_cmd    = 3'd0;
    drv_text_w = 1'b0;
    drv_ack    = 1'b0;
    model_reset();
    #1;
    compare_all();
    checkOutput("rst_round", obs_round, 0);
    checkOutput("rst_rd_idx", obs_rd_idx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      idle_cycles($urandom_range(0, 2));
      applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic write_cmd(input bit [2:0] c);
    applyStimulus(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic send_acks(input int n);
    for (int i = 0; i < n; i++) begin
      idle_cycles($urandom_range(0, 2));
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
      if (obs_done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", seen, 1'b1);
    idle_cycles(2);
  endtask

  task automatic wait_round(input int r);
    for (int i = 0; i < 200; i++) begin
      if (has_block && model_k() == r) break;
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    end
    checkOutput("at_round_en", obs_round_en, 1'b1);
    checkOutput("at_round", obs_round, r);
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus($urandom_range(0, 15) == 0, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
  endtask

  // Main sequence: directed scenarios first, then randomized traffic on each instance.
  initial begin
    rst_n      = 1'b0;
    sel        = 1'b0;
    drv_cmd_w  = 1'b0;
    drv_cmd    = 3'd0;
    drv_text_w = 1'b0;
    drv_ack    = 1'b0;
    edge_n     = 0;
    m_rounds   = 64;
    m_digest   = 8;
    m_init_bit = 1'b0;
    model_reset();
    @(negedge clk);
    $display("[TB] instance A: 64 rounds, 8 digest words");
    do_reset();

    load_words(10);
    write_cmd(3'b010);
    idle_cycles(5);
    load_words(6);
    wait_done();

    load_words(16);
    write_cmd(3'b110);
    wait_done();

    write_cmd(3'b001);
    idle_cycles(1);
    send_acks(8);
    send_acks(1);
    idle_cycles(2);

    load_words(16);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    write_cmd(3'b010);
    wait_round(20);
    write_cmd(3'b001);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    wait_done();
    write_cmd(3'b000);
    idle_cycles(2);

    load_words(16);
    write_cmd(3'b011);
    idle_cycles(1);
    send_acks(8);
    wait_done();

    write_cmd(3'b001);
    idle_cycles(1);
    send_acks(3);
    write_cmd(3'b001);
    idle_cycles(1);
    send_acks(8);
    idle_cycles(2);

    load_words(16);
    write_cmd(3'b010);
    wait_round(30);
    do_reset();
    idle_cycles(2);

    random_phase(1500);

    sel      = 1'b1;
    m_rounds = 80;
    m_digest = 5;
    $display("[TB] instance B: 80 rounds, 5 digest words");
    do_reset();
    load_words(16);
    write_cmd(3'b010);
    wait_done();
    write_cmd(3'b001);
    idle_cycles(1);
    send_acks(5);
    send_acks(1);
    idle_cycles(2);
    random_phase(800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha_round_ctrl.md
Name: sha_round_ctrl

Overview:
- Parametrised command/sequencing controller for the iterative hash cores (SHA-1/224/256 family).
- Holds the host command/status register and counts message words loaded into the block buffer.
- Runs a configurable number of compression rounds, then sequences digest readout word by word.
- Drives the datapath: init, round enable/index, final add, read index. Contains no hash arithmetic.

Parameters:
ROUNDS, 64, compression rounds per block (2..127).
BLOCK_WORDS, 16, message words per block (2..16).
DIGEST_WORDS, 8, digest words read out per result (1..8; 7 for SHA-224, 5 for SHA-1).
RW, 7, round counter width; 2**RW > ROUNDS.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-low
cmd_i  in  3  command write data {Round, W, R}
cmd_w_i  in  1  command write strobe
cmd_o  out  4  status {Busy, Round, W, R}
text_w_i  in  1  host message-word write strobe
wr_idx_o  out  4  buffer slot for the current text_w_i word
blk_full_o  out  1  BLOCK_WORDS words loaded
init_o  out  1  1-cycle pulse: load IV (first block)
round_en_o  out  1  datapath performs one round this cycle
round_o  out  RW  current round index
final_o  out  1  1-cycle pulse: add working vars into digest
done_o  out  1  1-cycle pulse: block finished
rd_vld_o  out  1  digest readout active
rd_idx_o  out  3  digest word index presented to host
rd_ack_i  in  1  host consumed current digest word
err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_i low, asynchronous): FSM=IDLE. cmd=0, word count=0, round=0, read counter=0, err=0. All pulses and outputs are 0.
- Command register:
  - cmd_w_i while not busy writes cmd[2:0].
  - cmd_w_i while busy is ignored and sets err.
  - cmd[3] mirrors busy, registered, one cycle late.
  - W (bit1) clears on the cycle start is accepted. R (bit0) clears on the cycle the read sequence is loaded. Round (bit2) is held until rewritten.
- Word loading: in IDLE, text_w_i with count<BLOCK_WORDS writes slot wr_idx_o=count, then count+1. blk_full_o = (count==BLOCK_WORDS).
  - text_w_i when full, or when not IDLE: ignored, err set.
- Start: in IDLE with cmd[1]=1 and blk_full_o=1, start is accepted at edge T.
  - If cmd[1]=1 but not full, W stays pending with no error.
  - At T: FSM->ROUND, busy=1, round=0, count=0. init_o is high during cycle T+1 only if cmd[2]==0.
- ROUND: round_en_o=1 for cycles T+1..T+ROUNDS, with round_o=0..ROUNDS-1. After round ROUNDS-1, FSM->FINAL.
- FINAL: final_o=1 for one cycle (T+ROUNDS+1), then FSM->DONE.
- DONE: done_o=1 for one cycle (T+ROUNDS+2). busy clears at that edge; FSM->IDLE. cmd[3] falls one cycle later.
- Readout: in IDLE with cmd[0]=1, the read counter loads DIGEST_WORDS, rd_vld_o=1 and rd_idx_o=0.
  - Each rd_ack_i advances rd_idx_o. The ack on index DIGEST_WORDS-1 ends the sequence (rd_vld_o=0).
  - R pending while busy waits for IDLE.
  - rd_ack_i with rd_vld_o=0 is ignored and sets err.
  - cmd[0] re-asserted mid-read restarts at index 0.
- Simultaneous events in IDLE with both W and R pending: read wins; start waits until the read sequence ends. Start and readout never overlap.
- Start is blocked while rd_vld_o=1.
- err clears only on a valid (non-busy) cmd_w_i or reset.
- Asynchronous reset mid-round aborts immediately: all outputs return to reset values and loaded words are discarded.
- Counters never wrap: round stops at ROUNDS-1, word count saturates at BLOCK_WORDS, read index stops at DIGEST_WORDS-1.

Test Plan:
- Reset, write 16 words, cmd_i=3'b010 -> wr_idx_o 0..15, blk_full_o=1. init_o at T+1, round_en_o for 64 cycles (round_o 0..63), final_o at T+65, done_o at T+66, cmd_o[3] 1 then 0.
- cmd_i=3'b010 after only 10 words -> no start. Write 6 more -> start accepted the cycle after blk_full_o rises, err_o=0.
- Second block with cmd_i=3'b110 -> init_o stays 0, rounds and final as in the first block.
- After done, cmd_i=3'b001 with DIGEST_WORDS=8 -> rd_vld_o=1, rd_idx_o steps 0..7 on eight rd_ack_i, rd_vld_o=0 after the 8th. A ninth ack sets err_o=1.
- cmd_w_i during round 20, a 17th text_w_i, and text_w_i while busy -> each ignored, err_o=1, rounds unaffected. The next idle cmd write clears err_o.
- rst_i low at round 30 -> immediate return to reset state. Parameter run ROUNDS=80, DIGEST_WORDS=5 -> 80 round_en_o cycles, read indices 0..4.
